// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit and the CPU core.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W     = 4;
  localparam int unsigned FETCH_DATA_W     = 8;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction valid/ready handshake between the fetch unit and its consumer.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FETCH_DATA_W
) ();

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instruction;

  modport master (output instr_valid, output instruction, input instr_ready);
  modport slave  (input instr_valid, input instruction, output instr_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and synchronous clear.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = store[rd_ptr];

  // Pointer and occupancy tracking; clear empties the buffer like reset.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; unread slots are never presented as valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program memory, program counter and fetch FSM feeding a prefetch FIFO.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned DATA_W     = FETCH_DATA_W,
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0]   prog_data,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                start,
  input  logic                flush,
  instr_fetch_unit_if.master  bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] end_reg;
  logic              fetch_fin;
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign push_c          = (state == S_RUN) && !fetch_fin && !fifo_full && !flush;
  assign pop_c           = bus.instr_valid && bus.instr_ready;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instruction = fifo_empty ? '0 : fifo_dout;
  assign busy            = (state == S_RUN);
  assign done            = (state == S_DONE);

  // Program memory is writable only outside RUN and is never cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state != S_RUN)) mem[prog_addr] <= prog_data;
  end

  // Fetch FSM: start latches end_addr, RUN pushes until end_addr is fetched and drained.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      end_reg   <= '0;
      fetch_fin <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      pc        <= '0;
      fetch_fin <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            end_reg   <= end_addr;
            pc        <= '0;
            fetch_fin <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (push_c) begin
            pc <= pc + ADDR_W'(1);
            if (pc == end_reg) fetch_fin <= 1'b1;
          end
          if (fetch_fin && (fifo_count == '0)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push_c),
    .pop     (pop_c),
    .din     (mem[pc]),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply stage directly upstream of the accumulator CPU core; drives that core's 8-bit instruction input.
- Holds a small loadable program memory and a program counter.
- Prefetches instructions into a shallow FIFO and presents them on a valid/ready interface.
- The CPU-side control consumes one instruction per FETCH state via `instr_ready`.

Parameters:
- `ADDR_W`, 4, program memory address width (2^ADDR_W entries).
- `DATA_W`, 8, instruction width.
- `FIFO_DEPTH`, 4, prefetch buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `prog_we`  in  1  program memory write strobe.
- `prog_addr`  in  ADDR_W  program memory write address.
- `prog_data`  in  DATA_W  program memory write data.
- `end_addr`  in  ADDR_W  last address to fetch; sampled at start.
- `start`  in  1  begin fetching from address 0.
- `flush`  in  1  abort run, empty FIFO, return to IDLE.
- `instr_valid`  out  1  FIFO head holds an instruction.
- `instr_ready`  in  1  consumer accepts the head this cycle.
- `instruction`  out  DATA_W  FIFO head.
- `pc`  out  ADDR_W  next address to fetch.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.

Behaviour:
- Reset (`reset_n` low at edge), regardless of state:
  - state = IDLE; `pc`, FIFO count, `instr_valid`, `instruction`, `busy`, `done` all 0.
  - Program memory contents are retained (not cleared); contents are undefined at power-up.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - `prog_we` writes `mem[prog_addr]` at the edge.
  - `start` loads `end_addr` into an internal register, sets `pc` = 0, goes to RUN.
- RUN:
  - Each cycle where FIFO count < FIFO_DEPTH and the fetch is not finished, push `mem[pc]` (combinational read) and set `pc` = `pc`+1, modulo 2^ADDR_W.
  - The fetch is finished once `mem[end_addr]` has been pushed.
  - Leave RUN for DONE when the fetch is finished and the FIFO is empty.
  - `prog_we` and `start` are ignored.
- DONE:
  - `instr_valid` = 0.
  - `prog_we` is accepted.
  - `start` restarts exactly as from IDLE.
- Latency: the first push occurs on the first edge in RUN, so `instr_valid` rises one cycle after `busy` rises.
- Handshake:
  - Transfer occurs when `instr_valid` && `instr_ready`.
  - While `instr_valid` && !`instr_ready`, `instruction` holds stable.
  - `instr_ready` while `instr_valid` = 0 has no effect.
- FIFO full rule:
  - A push requires the registered count < FIFO_DEPTH; there is no bypass.
  - A pop while full frees a slot for the next cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
- Wrap-around: with `end_addr` = 2^ADDR_W−1, all entries are fetched and `pc` wraps to 0 after the last fetch. `pc` after a run = (`end_addr`+1) mod 2^ADDR_W.
- `flush`:
  - Has priority over `start` and push/pop.
  - Next cycle: FIFO empty, `instr_valid` = 0, `pc` = 0, state IDLE.
- `reset_n` has priority over everything.
- `done` and `busy` are never both 1.

Decomposition:
- Shared package (`fetch_pkg`): state encodings `S_IDLE`/`S_RUN`/`S_DONE`; default `ADDR_W`/`DATA_W`/`FIFO_DEPTH` constants shared with the CPU core.
- One sub-module: `sync_fifo`. It is parameterised on width and depth, uses the same clock and synchronous active-low reset, and provides push/pop/full/empty/count.
- Program memory and FSM live in `instr_fetch_unit`.

Test Plan:
1. Load `mem[0..3]` = 0x03, 0x12, 0x05, 0x1F; `end_addr` = 3; start; `instr_ready` = 1 → 0x03, 0x12, 0x05, 0x1F delivered in order on consecutive cycles, first one cycle after `busy` rises; `done` = 1 after the last transfer, `pc` = 4.
2. Same program with 8 entries and `end_addr` = 7; `instr_ready` = 0 → FIFO fills to 4, `pc` = 4, `instruction` held at 0x03. Release `instr_ready` → remaining entries in order, with no duplicates or drops.
3. `end_addr` = 15, `mem[i]` = i → 16 instructions 0x00..0x0F delivered; `pc` wraps to 0; `done` = 1.
4. Assert `flush` mid-run after 2 transfers → next cycle `instr_valid` = 0, `pc` = 0, state IDLE; a fresh start re-delivers from `mem[0]`.
5. Pulse `reset_n` low for one cycle mid-run → all outputs 0 next cycle; memory retained; start reproduces the identical stream.
6. `prog_we` to addr 1 with 0xAA during RUN → ignored; the stream still shows the original `mem[1]`. The same write in DONE takes effect on the next run.
